// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter
// Shares one 2D-DCT engine among NCH component streams, one whole block of
// BLOCK_LEN samples at a time. Grants are round-robin and held for a whole
// block. Data passes through combinationally with zero latency, tagged with
// the channel id and first/last-of-block markers.
//
// Handshake: a beat moves on a channel when its valid and ready are both high
// in the same cycle. Valid never waits on ready. in_valid doubles as the
// channel's request, and out_valid/out_data follow the granted channel's
// inputs directly.
//
// Optional build macro DCT_ARB_STATS_EN adds stat_clr/stat_blocks, which hold
// saturating 16-bit completed-block counters, one per channel.
module dct_block_arbiter #(
    parameter int NCH       = 3,
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH-1:0]            in_valid,
    input  logic [NCH*DATA_W-1:0]     in_data,
    output logic [NCH-1:0]            in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [$clog2(NCH)-1:0]    out_ch,
    output logic                      out_first,
    output logic                      out_last,
    input  logic                      halt,
    output logic                      idle
`ifdef DCT_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NCH*16-1:0]         stat_blocks
`endif
);

    localparam int CH_W  = $clog2(NCH);
    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
    localparam logic [CH_W:0]    NCH_EXT  = (CH_W + 1)'(NCH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CH_W-1:0]  grant;
    logic [CH_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;

    logic             busy;
    logic             xfer;
    logic             cnt_at_last;
    logic             eob;
    logic             any_req;
    logic [CH_W-1:0]  nxt_ptr;
    logic [CH_W-1:0]  pick_start;
    logic [2*NCH-1:0] req_dbl;
    logic [CH_W-1:0]  pick_offs;
    logic [CH_W:0]    pick_sum;
    logic [CH_W-1:0]  pick;

    // Round-robin pick: rotate the requests so pick_start sits at bit 0, take
    // the lowest set bit, then rotate the index back with an explicit mod-NCH.
    // In BUSY the pick is only used at end of block, where the search starts
    // just past the finishing channel.
    always_comb begin
        nxt_ptr    = (grant == CH_LAST) ? '0 : grant + 1'b1;
        pick_start = (state == BUSY) ? nxt_ptr : ptr;
        req_dbl    = {in_valid, in_valid} >> pick_start;
        pick_offs  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_dbl[k]) pick_offs = CH_W'(k);
        end
        pick_sum = {1'b0, pick_start} + {1'b0, pick_offs};
        pick     = (pick_sum >= NCH_EXT) ? CH_W'(pick_sum - NCH_EXT) : pick_sum[CH_W-1:0];
        any_req  = |in_valid;
    end

    // Zero-latency pass-through of the granted channel, plus beat tagging.
    always_comb begin
        busy        = (state == BUSY);
        out_valid   = busy & in_valid[grant];
        xfer        = out_valid & out_ready;
        cnt_at_last = (cnt == CNT_LAST);
        eob         = xfer & cnt_at_last;
        out_first   = out_valid & (cnt == '0);
        out_last    = out_valid & cnt_at_last;
        out_ch      = busy ? grant : '0;
        idle        = ~busy;
        out_data    = '0;
        in_ready    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (busy && (grant == CH_W'(i))) begin
                out_data    = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = out_ready;
            end
        end
    end

    // Grant FSM: one-cycle grant from IDLE, block-locked grant in BUSY, and a
    // back-to-back regrant at end of block unless halt is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt && any_req) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (cnt_at_last) begin
                            ptr <= nxt_ptr;
                            cnt <= '0;
                            if (!halt && any_req) grant <= pick;
                            else                  state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCT_ARB_STATS_EN
    logic [15:0] blk_cnt [NCH];

    // Per-channel completed-block counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) blk_cnt[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NCH; i++) blk_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (eob && (grant == CH_W'(i)) && (blk_cnt[i] != 16'hFFFF))
                    blk_cnt[i] <= blk_cnt[i] + 16'd1;
            end
        end
    end

    // Flatten the counters, channel i in bits [i*16 +: 16].
    always_comb begin
        stat_blocks = '0;
        for (int i = 0; i < NCH; i++) stat_blocks[i*16 +: 16] = blk_cnt[i];
    end
`endif

endmodule

// File: tb/tb_dct_block_arbiter.sv
// tb_dct_block_arbiter
// Directed bench for dct_block_arbiter with a block-level reference model
// checked on every falling edge, plus hand-computed checks at key beats.
module tb_dct_block_arbiter;
    localparam int NCH       = 3;
    localparam int DATA_W    = 8;
    localparam int BLOCK_LEN = 64;
    localparam int CH_W      = $clog2(NCH);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NCH-1:0]        in_valid;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH-1:0]        in_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic                  out_ready;
    logic [CH_W-1:0]       out_ch;
    logic                  out_first;
    logic                  out_last;
    logic                  halt;
    logic                  idle;
`ifdef DCT_ARB_STATS_EN
    logic                  stat_clr;
    logic [NCH*16-1:0]     stat_blocks;
`endif

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dct_block_arbiter #(.NCH(NCH), .DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_first (out_first),
        .out_last  (out_last),
        .halt      (halt),
        .idle      (idle)
`ifdef DCT_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_blocks (stat_blocks)
`endif
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Fresh sample data on every channel every cycle.
    initial begin
        in_data = '0;
        forever begin
            @(posedge clk);
            #1;
            in_data = (NCH*DATA_W)'($urandom);
        end
    end

    // ---------------- reference model ----------------
    // Block-level view: who owns the engine, how many beats of the block are
    // done, and where the next round-robin search starts.
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_beats;
    int          m_blocks [NCH];
    logic [7:0]  grant_log [$];
    logic [7:0]  exp_q [$];

    function automatic int rr_pick(input int start, input logic [NCH-1:0] req);
        for (int k = 0; k < NCH; k++) begin
            if (req[(start + k) % NCH]) return (start + k) % NCH;
        end
        return -1;
    endfunction

    // Scoreboard compare on the falling edge, then advance the model to the
    // state the DUT should hold after the next rising edge.
    always @(negedge clk) begin
        logic              e_ov;
        logic [DATA_W-1:0] e_od;
        logic [NCH-1:0]    e_ir;
        int                e_ch;
        int                p;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_beats = 0;
            for (int i = 0; i < NCH; i++) m_blocks[i] = 0;
        end
        e_ov = m_busy && in_valid[m_owner];
        e_od = m_busy ? in_data[m_owner*DATA_W +: DATA_W] : '0;
        e_ir = (m_busy && out_ready) ? (NCH'(1) << m_owner) : '0;
        e_ch = m_busy ? m_owner : 0;
        chk("sb_out_valid", 32'(out_valid), 32'(e_ov));
        chk("sb_out_data",  32'(out_data),  32'(e_od));
        chk("sb_in_ready",  32'(in_ready),  32'(e_ir));
        chk("sb_out_ch",    32'(out_ch),    32'(e_ch));
        chk("sb_out_first", 32'(out_first), 32'(e_ov && m_beats == 0));
        chk("sb_out_last",  32'(out_last),  32'(e_ov && m_beats == BLOCK_LEN - 1));
        chk("sb_idle",      32'(idle),      32'(!m_busy));
        if (rst_n) begin
            if (!m_busy) begin
                p = rr_pick(m_ptr, in_valid);
                if (!halt && p >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = p;
                    m_beats = 0;
                    grant_log.push_back(8'(p));
                end
            end else if (e_ov && out_ready) begin
                if (m_beats == BLOCK_LEN - 1) begin
                    m_blocks[m_owner]++;
                    m_ptr   = (m_owner + 1) % NCH;
                    m_beats = 0;
                    p = rr_pick(m_ptr, in_valid);
                    if (!halt && p >= 0) begin
                        m_owner = p;
                        grant_log.push_back(8'(p));
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_beats++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Let the current block finish under halt, then drop all requests.
    task automatic finish_to_idle(input logic [NCH-1:0] keep);
        in_valid  = keep;
        halt      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && !idle; i++) step(1);
        chk("reach_idle", 32'(idle), 32'd1);
        in_valid = '0;
        halt     = 1'b0;
        step(2);
    endtask

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        halt      = 1'b0;
`ifdef DCT_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        step(3);
        chk("reset_idle",      32'(idle),      32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd0);

        // All channels requesting, sink always ready: 0,1,2,0 with no bubbles.
        rst_n     = 1'b1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        step(1);
        chk("t1_b0_ch",    32'(out_ch),    32'd0);
        chk("t1_b0_first", 32'(out_first), 32'd1);
        step(63);
        chk("t1_b63_last", 32'(out_last),  32'd1);
        chk("t1_b63_ch",   32'(out_ch),    32'd0);
        step(1);
        chk("t1_ch1_ch",    32'(out_ch),    32'd1);
        chk("t1_ch1_first", 32'(out_first), 32'd1);
        step(64);
        chk("t1_ch2_ch",    32'(out_ch),    32'd2);
        chk("t1_ch2_first", 32'(out_first), 32'd1);
        step(64);
        chk("t1_ch0b_ch",    32'(out_ch),    32'd0);
        chk("t1_ch0b_first", 32'(out_first), 32'd1);
        finish_to_idle(3'b001);

        // Only ch1, sink ready toggling: 128-cycle block, then re-grant of ch1.
        in_valid  = 3'b010;
        out_ready = 1'b1;
        step(1);
        for (int i = 0; i < 128; i++) begin
            out_ready = (i % 2 == 0);
            #1;
            chk("t2_other_ready", 32'(in_ready & 3'b101), 32'd0);
            if (i == 0)   chk("t2_first",      32'(out_first), 32'd1);
            if (i == 125) chk("t2_last_hold",  32'(out_last),  32'd1);
            if (i == 126) chk("t2_last_xfer",  32'(out_last),  32'd1);
            if (i == 127) chk("t2_regrant",    32'({out_ch, out_first}), 32'({2'd1, 1'b1}));
            step(1);
        end
        finish_to_idle(3'b010);

        // ch0 block, ch2 requests mid-block: no preemption, ch2 next.
        in_valid = 3'b001;
        step(1);
        chk("t3_b0_ch", 32'(out_ch), 32'd0);
        step(10);
        in_valid = 3'b101;
        #1;
        chk("t3_b10_ch", 32'(out_ch), 32'd0);
        step(53);
        chk("t3_b63", 32'({out_ch, out_last}), 32'({2'd0, 1'b1}));
        step(1);
        chk("t3_ch2", 32'({out_ch, out_first}), 32'({2'd2, 1'b1}));

        // halt at beat 30 of the ch2 block: block completes, then idle.
        step(30);
        halt = 1'b1;
        step(33);
        chk("t4_b63", 32'({out_ch, out_last}), 32'({2'd2, 1'b1}));
        step(1);
        chk("t4_idle",      32'(idle),      32'd1);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        step(5);
        chk("t4_still_idle", 32'(idle), 32'd1);
        in_valid = 3'b111;
        halt     = 1'b0;
        step(1);
        chk("t4_resume", 32'({out_ch, out_first}), 32'({2'd0, 1'b1}));

        // Asynchronous reset at beat 20, then lowest valid index from ptr=0.
        step(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_idle",      32'(idle),      32'd1);
        chk("t5_in_ready",  32'(in_ready),  32'd0);
        chk("t5_out_first", 32'(out_first), 32'd0);
        step(2);
        in_valid = 3'b110;
        rst_n    = 1'b1;
        step(1);
        chk("t5_first_grant", 32'({out_ch, out_first}), 32'({2'd1, 1'b1}));
        finish_to_idle(3'b010);

        // Grant order over the whole run, written out by hand.
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd1, 8'd0, 8'd2, 8'd0, 8'd1};
        chk("grant_log_len", 32'(grant_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
            chk("grant_log", 32'(grant_log[i]), 32'(exp_q[i]));

`ifdef DCT_ARB_STATS_EN
        for (int i = 0; i < NCH; i++)
            chk("stat_blocks", 32'(stat_blocks[i*16 +: 16]), 32'(m_blocks[i]));
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        chk("stat_clr", 32'(stat_blocks), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
